// File: rtl/tc_pl_cap_gain_auto.sv
// Capture-path gain autoranger.
// Measures the peak |adc| over a sample window, steps the gain index against
// hi/lo thresholds, and funnels auto, manual and power-up gain loads through
// a single gain_en/gain_value request channel with completion handshake.
module tc_pl_cap_gain_auto #(
  parameter int GAIN_W    = 2,
  parameter int DATA_W    = 16,
  parameter int WIN_W     = 16,
  parameter int INIT_GAIN = 0,
  parameter int TO_CYC    = 1000000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_auto_en,
  input  logic              i_man_gain_req,
  input  logic [GAIN_W-1:0] i_man_gain_value,
  input  logic [DATA_W-1:0] i_adc_data,
  input  logic              i_adc_valid,
  input  logic [WIN_W-1:0]  i_win_len,
  input  logic [DATA_W-2:0] i_th_hi,
  input  logic [DATA_W-2:0] i_th_lo,
  input  logic [31:0]       i_settle_cyc,
  input  logic              i_clr_err,
  output logic [GAIN_W-1:0] o_gain_value,
  output logic              o_gain_en,
  input  logic              i_gain_cmpt,
  output logic [GAIN_W-1:0] o_cur_gain,
  output logic [DATA_W-2:0] o_peak_out,
  output logic              o_busy,
  output logic              o_over_rng,
  output logic              o_timeout_err
);

  localparam logic [GAIN_W-1:0] GMAX   = '1;
  localparam logic [GAIN_W-1:0] INIT_G = GAIN_W'(INIT_GAIN);
  localparam logic [31:0]       TO_LIM = 32'(TO_CYC);
  localparam logic signed [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_MEAS, S_DECIDE, S_REQ, S_WAIT, S_SETTLE
  } state_t;

  state_t            r_state;
  logic              r_pend;
  logic [GAIN_W-1:0] r_pend_val;
  logic [GAIN_W-1:0] r_gain_value;
  logic              r_gain_en;
  logic [GAIN_W-1:0] r_cur_gain;
  logic [DATA_W-2:0] r_peak;
  logic [DATA_W-2:0] r_peak_out;
  logic [WIN_W-1:0]  r_win_cnt;
  logic [31:0]       r_to_cnt;
  logic [31:0]       r_set_cnt;
  logic              r_over_rng;
  logic              r_timeout_err;

  // Magnitude of a signed sample; the most negative code has no positive
  // twin, so it clips to the largest positive magnitude.
  function automatic logic [DATA_W-2:0] sat_abs(input logic signed [DATA_W-1:0] x);
    if (x == SMIN)
      sat_abs = '1;
    else if (x[DATA_W-1])
      sat_abs = (~x[DATA_W-2:0]) + (DATA_W-1)'(1);
    else
      sat_abs = x[DATA_W-2:0];
  endfunction

  logic signed [DATA_W-1:0] w_adc_s;
  logic [DATA_W-2:0] w_abs;
  logic [DATA_W-2:0] w_new_peak;
  logic [WIN_W-1:0]  w_win_eff;
  logic [WIN_W:0]    w_cnt_nxt;
  logic              w_win_done;
  logic              w_settle_done;
  logic              w_req_go;
  logic [GAIN_W-1:0] w_req_tgt;
  logic              w_to_meas;
  logic              w_over_set;
  logic              w_to_set;

  assign w_adc_s       = signed'(i_adc_data);
  assign w_abs         = sat_abs(w_adc_s);
  assign w_new_peak    = (w_abs > r_peak) ? w_abs : r_peak;
  assign w_win_eff     = (i_win_len == '0) ? WIN_W'(1) : i_win_len;
  assign w_cnt_nxt     = {1'b0, r_win_cnt} + (WIN_W+1)'(1);
  assign w_win_done    = (w_cnt_nxt >= {1'b0, w_win_eff});
  assign w_settle_done = (({1'b0, r_set_cnt} + 33'd1) >= {1'b0, i_settle_cyc});

  // Sticky-flag set events: over-range only when already at the lowest gain,
  // timeout only if no completion arrives in the expiry cycle itself.
  assign w_over_set = (r_state == S_DECIDE) && !r_pend &&
                      (r_peak_out >= i_th_hi) && (r_cur_gain == '0);
  assign w_to_set   = (r_state == S_WAIT) && !i_gain_cmpt && (r_to_cnt >= TO_LIM);

  // Request arbitration: pending (manual/init) beats any auto step, and the
  // hi check beats the lo check so overlapping thresholds resolve downward.
  always_comb begin
    w_req_go  = 1'b0;
    w_req_tgt = r_cur_gain;
    w_to_meas = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pend) begin
          w_req_go  = 1'b1;
          w_req_tgt = r_pend_val;
        end else begin
          w_to_meas = i_auto_en;
        end
      end
      S_DECIDE: begin
        if (r_pend) begin
          w_req_go  = 1'b1;
          w_req_tgt = r_pend_val;
        end else if (r_peak_out >= i_th_hi) begin
          if (r_cur_gain != '0) begin
            w_req_go  = 1'b1;
            w_req_tgt = r_cur_gain - GAIN_W'(1);
          end else begin
            w_to_meas = i_auto_en;
          end
        end else if (r_peak_out < i_th_lo) begin
          if (r_cur_gain != GMAX) begin
            w_req_go  = 1'b1;
            w_req_tgt = r_cur_gain + GAIN_W'(1);
          end else begin
            w_to_meas = i_auto_en;
          end
        end else begin
          w_to_meas = i_auto_en;
        end
      end
      default: ;
    endcase
  end

  // Main controller: window measurement, request issue, completion wait, settle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_pend       <= 1'b1;
      r_pend_val   <= INIT_G;
      r_gain_value <= INIT_G;
      r_gain_en    <= 1'b0;
      r_cur_gain   <= INIT_G;
      r_peak       <= '0;
      r_peak_out   <= '0;
      r_win_cnt    <= '0;
      r_to_cnt     <= '0;
      r_set_cnt    <= '0;
    end else begin
      r_gain_en <= 1'b0;
      if (i_man_gain_req) begin
        r_pend     <= 1'b1;
        r_pend_val <= i_man_gain_value;
      end
      if (w_req_go) begin
        // A manual request landing in the issue cycle stays pending.
        if (!i_man_gain_req) r_pend <= 1'b0;
        r_gain_value <= w_req_tgt;
        r_gain_en    <= 1'b1;
        r_to_cnt     <= '0;
        r_state      <= S_REQ;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_to_meas) begin
              r_peak    <= '0;
              r_win_cnt <= '0;
              r_state   <= S_MEAS;
            end
          end
          S_MEAS: begin
            if (!i_auto_en) begin
              r_state <= S_IDLE;
            end else if (i_adc_valid) begin
              r_peak    <= w_new_peak;
              r_win_cnt <= w_cnt_nxt[WIN_W-1:0];
              if (w_win_done) begin
                r_peak_out <= w_new_peak;
                r_state    <= S_DECIDE;
              end
            end
          end
          S_DECIDE: begin
            if (w_to_meas) begin
              r_peak    <= '0;
              r_win_cnt <= '0;
              r_state   <= S_MEAS;
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_REQ: begin
            // Counter holds the number of cycles elapsed since the strobe.
            r_to_cnt <= 32'd1;
            r_state  <= S_WAIT;
          end
          S_WAIT: begin
            if (i_gain_cmpt) begin
              r_cur_gain <= r_gain_value;
              r_set_cnt  <= '0;
              r_state    <= S_SETTLE;
            end else if (r_to_cnt >= TO_LIM) begin
              r_state <= S_IDLE;
            end else begin
              r_to_cnt <= r_to_cnt + 32'd1;
            end
          end
          S_SETTLE: begin
            if (w_settle_done) r_state <= S_IDLE;
            else               r_set_cnt <= r_set_cnt + 32'd1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Sticky error flags; a set event in the clear cycle wins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_over_rng    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (i_clr_err) begin
        r_over_rng    <= 1'b0;
        r_timeout_err <= 1'b0;
      end
      if (w_over_set) r_over_rng    <= 1'b1;
      if (w_to_set)   r_timeout_err <= 1'b1;
    end
  end

  assign o_gain_value  = r_gain_value;
  assign o_gain_en     = r_gain_en;
  assign o_cur_gain    = r_cur_gain;
  assign o_peak_out    = r_peak_out;
  assign o_busy        = (r_state != S_IDLE);
  assign o_over_rng    = r_over_rng;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: doc/tc_pl_cap_gain_auto.md
Name: tc_pl_cap_gain_auto

Overview:
Autorange controller for the capture gain path. Measures the peak absolute ADC amplitude over a programmable sample window and steps the gain index up or down against hi/lo thresholds. Issues one-cycle gain_en/gain_value requests to the cap-gain control block and waits for gain_cmpt, then discards samples for a settle period before measuring again. Also arbitrates software manual gain requests and a power-up initial gain load into the same single request channel.

Parameters:
GAIN_W, 2, gain index width; indices 0..2^GAIN_W-1, higher index = higher gain
DATA_W, 16, signed ADC sample width
WIN_W, 16, window length counter width
INIT_GAIN, 0, gain index programmed after reset
TO_CYC, 1000000, gain_cmpt timeout in clk cycles

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
auto_en  in  1  level; 1 = autorange running
man_gain_req  in  1  pulse; request manual gain man_gain_value
man_gain_value  in  GAIN_W  manual gain index
adc_data  in  DATA_W  signed sample
adc_valid  in  1  sample strobe
win_len  in  WIN_W  samples per measurement window; 0 treated as 1
th_hi  in  DATA_W-1  step gain down when peak >= th_hi
th_lo  in  DATA_W-1  step gain up when peak < th_lo
settle_cyc  in  32  post-change discard time in cycles
clr_err  in  1  pulse; clears sticky error flags
gain_value  out  GAIN_W  requested gain index, held stable between requests
gain_en  out  1  one-cycle request strobe
gain_cmpt  in  1  completion pulse from gain control
cur_gain  out  GAIN_W  last confirmed gain index
peak_out  out  DATA_W-1  peak of last completed window
busy  out  1  1 in any state except IDLE
over_rng  out  1  sticky: peak >= th_hi at gain 0
timeout_err  out  1  sticky: gain_cmpt not seen within TO_CYC

Behaviour:
- Reset (async, rst=0): state IDLE; gain_value=INIT_GAIN, cur_gain=INIT_GAIN, gain_en=0, peak_out=0, busy=0, over_rng=0, timeout_err=0; internal pending request set with INIT_GAIN.
- Manual request: man_gain_req latches man_gain_value into a pending slot at any time; a later request overwrites an earlier one. Pending is serviced at IDLE or DECIDE and has priority over any auto decision.
- States: IDLE, MEAS, DECIDE, REQ, WAIT_CMPT, SETTLE.
- IDLE: if pending -> REQ with the pending value. Else if auto_en -> MEAS, clearing the peak and the window count.
- MEAS: on each adc_valid, compute abs(adc_data); -2^(DATA_W-1) saturates to 2^(DATA_W-1)-1. Peak = max. Count valid samples; after the max(win_len,1)th sample -> DECIDE, peak_out updated that cycle. auto_en=0 in MEAS -> IDLE immediately, peak_out unchanged.
- DECIDE (1 cycle), evaluated in order:
  - pending -> REQ (pending value).
  - peak>=th_hi: if cur_gain>0 -> REQ with cur_gain-1; else set over_rng and go to MEAS.
  - peak<th_lo: if cur_gain<max -> REQ with cur_gain+1; else go to MEAS.
  - otherwise -> MEAS (or IDLE if auto_en=0).
  - A target equal to cur_gain still issues a request only if it came from pending (manual/init); auto never requests an unchanged gain.
- REQ (1 cycle): gain_value<=target, gain_en=1, clear pending, clear timeout counter -> WAIT_CMPT. Request-to-gain_en latency from DECIDE: 1 cycle.
- WAIT_CMPT: on gain_cmpt: cur_gain<=gain_value -> SETTLE. Otherwise after TO_CYC cycles: set timeout_err, cur_gain unchanged -> IDLE. gain_cmpt and expiry in the same cycle: cmpt wins. gain_cmpt outside WAIT_CMPT is ignored.
- SETTLE: count settle_cyc cycles, ignoring adc_valid; settle_cyc=0 leaves after 1 cycle. Exit -> IDLE. Auto re-enters MEAS from IDLE, so a pending request made during busy is serviced first.
- auto_en deassert in REQ/WAIT_CMPT/SETTLE: transaction completes normally, then the block stays in IDLE.
- clr_err clears both sticky flags. If a set event occurs in the same cycle, set wins.
- Threshold compare is unsigned on DATA_W-1 bits; th_lo>th_hi is legal, and the hi check has precedence.

Test Plan:
1. Reset release, auto_en=0 -> one gain_en with gain_value=0 (INIT_GAIN); after gain_cmpt, cur_gain=0, busy drops after settle_cyc+1 cycles.
2. auto_en=1, cur_gain=0, win_len=4, th_lo=1000, th_hi=30000, samples 100,-200,50,-150 -> peak_out=200, gain_en with gain_value=1. Repeated windows step 1->2->3, then hold at 3 with no gain_en.
3. cur_gain=2, window contains sample -32768 -> peak_out=32767, request gain_value=1. At gain 0 the same input produces no gain_en and sets over_rng; clr_err clears it.
4. man_gain_req value 3 pulsed during SETTLE of an auto change -> after SETTLE, gain_en with gain_value=3 before any new MEAS.
5. gain_cmpt withheld, TO_CYC=100 -> timeout_err=1 at cycle 100 after gain_en, cur_gain unchanged, state IDLE. Same test with cmpt on cycle 100 -> no error.
6. Assert rst mid-WAIT_CMPT -> outputs return to reset values asynchronously, and an INIT_GAIN request is reissued after release.
